// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR              = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: reset vector, aligned redirect target, sequential advance or hold.
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        rst,
  input  logic        redirect,
  input  logic        advance,
  input  logic [31:0] pc,
  input  logic [31:0] pc_target,
  output logic [31:0] pc_next,
  output logic        misaligned
);

  always_comb begin
    misaligned = |pc_target[1:0];
    if (rst) begin
      pc_next = RESET_VECTOR;
    end else if (redirect) begin
      pc_next = word_align(pc_target);
    end else if (advance) begin
      pc_next = pc + PC_INCR;
    end else begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: request, wait for response, present to decode.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_target,
  input  logic        branch_valid,
  input  logic        pc_src,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic        misalign_err
);

  fetch_state_e state, state_next;
  logic         kill, kill_next;
  logic         redirect, issue, accept_rsp, target_misaligned;
  logic [31:0]  req_pc, pc_next;

  assign redirect       = branch_valid & pc_src;
  assign issue          = (state == REQ) & imem_req_ready;
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;

  pc_next_sel #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_next_sel (
    .rst       (rst),
    .redirect  (redirect),
    .advance   (issue),
    .pc        (pc),
    .pc_target (pc_target),
    .pc_next   (pc_next),
    .misaligned(target_misaligned)
  );

  // A redirect coinciding with the response kills it just like a pending kill flag.
  always_comb begin
    state_next = state;
    kill_next  = kill;
    accept_rsp = 1'b0;
    case (state)
      REQ: begin
        if (issue) begin
          state_next = WAIT;
          kill_next  = redirect;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          kill_next  = 1'b0;
          accept_rsp = ~(kill | redirect);
          state_next = (kill | redirect) ? REQ : OUT;
        end else if (redirect) begin
          kill_next = 1'b1;
        end
      end
      OUT: begin
        if (redirect || !stall) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    pc <= pc_next;
    if (issue) begin
      req_pc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REQ;
      kill         <= 1'b0;
      instr_valid  <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      kill         <= kill_next;
      instr_valid  <= (state_next == OUT);
      misalign_err <= redirect & target_misaligned;
      if (accept_rsp) begin
        instr    <= imem_rsp_data;
        instr_pc <= req_pc;
      end
    end
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, is the PC value loaded on reset.
REQ-002 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, is the synchronous, active-high reset.
REQ-004 Port pc_target, input, 32 bits, is the branch/jump target from the pc_target adder (pc + imm_ext).
REQ-005 Port branch_valid, input, 1 bit, qualifies pc_src for the current cycle.
REQ-006 Port pc_src, input, 1 bit, means take pc_target when branch_valid=1.
REQ-007 Port stall, input, 1 bit, means the downstream decode is not accepting instr this cycle.
REQ-008 Port imem_req_valid, output, 1 bit, is the fetch request valid.
REQ-009 Port imem_req_addr, output, 32 bits, is the fetch address.
REQ-010 Port imem_req_ready, input, 1 bit, is the memory request accept signal.
REQ-011 Port imem_rsp_valid, input, 1 bit, is the instruction response valid.
REQ-012 Port imem_rsp_data, input, 32 bits, is the instruction word.
REQ-013 Port instr_valid, output, 1 bit, means instr and instr_pc hold a valid instruction.
REQ-014 Port instr, output, 32 bits, is the fetched instruction.
REQ-015 Port instr_pc, output, 32 bits, is the address of instr.
REQ-016 Port pc, output, 32 bits, is the next address to fetch.
REQ-017 Port misalign_err, output, 1 bit, is a one-cycle pulse when a taken pc_target has bits[1:0] != 0.

Function
REQ-018 The FSM SHALL have states REQ, WAIT and OUT, with at most one outstanding request.
REQ-019 In REQ, imem_req_valid SHALL be 1 and imem_req_addr SHALL equal pc; on imem_req_ready=1 the FSM SHALL latch req_pc <= pc, set pc <= pc + 4 and go to WAIT.
REQ-020 Redirect SHALL mean branch_valid & pc_src. In any state, a redirect SHALL load pc <= {pc_target[31:2], 2'b00} at the next edge, taking priority over pc + 4.
REQ-021 If the request is outstanding or issued in the redirect cycle, a redirect SHALL set a kill flag.
REQ-022 In WAIT with imem_rsp_valid=1 and kill=1, the FSM SHALL drop the response, clear kill and go to REQ; instr_valid SHALL stay 0.
REQ-023 In WAIT with imem_rsp_valid=1 and kill=0, the FSM SHALL register instr <= imem_rsp_data and instr_pc <= req_pc, set instr_valid=1 and go to OUT.
REQ-024 In OUT, instr, instr_pc and instr_valid SHALL hold while stall=1; with stall=0 the instruction is consumed, instr_valid SHALL clear and the FSM SHALL go to REQ.
REQ-025 A redirect in OUT SHALL clear instr_valid at the next edge and go to REQ, regardless of stall.
REQ-026 imem_rsp_valid in REQ or OUT SHALL be ignored.
REQ-027 PC arithmetic is modulo 2^32: pc 32'hFFFFFFFC + 4 gives 32'h00000000.
REQ-028 Fetch latency SHALL be 1 cycle from response to instr_valid, giving a minimum of 3 cycles per instruction.

Reset
REQ-029 On rst=1 at an edge, the block SHALL set pc=RESET_VECTOR, state=REQ, kill=0, instr_valid=0, instr=0, instr_pc=0 and misalign_err=0.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding request; a late response SHALL arrive in REQ and be ignored per REQ-026.
REQ-031 rst SHALL take priority over every other input.

Structure
REQ-032 A shared package SHALL hold the state enum (REQ/WAIT/OUT), PC_INCR=4 and the RESET_VECTOR default.
REQ-033 Next-PC selection (reset / redirect / +4 / hold) plus alignment masking SHALL be one combinational sub-module, pc_next_sel; the FSM and registers stay in pc_fetch_ctrl.

Verification
REQ-034 Reset, then memory with ready=1 and 1-cycle response: instr_pc sequence SHALL be 0x0, 0x4, 0x8; imem_req_addr SHALL equal pc in each REQ cycle.
REQ-035 Redirect with pc_target=0x24 while in WAIT for 0x10: the 0x10 response SHALL be dropped, the next imem_req_addr SHALL be 0x24 and instr_pc SHALL be 0x24.
REQ-036 stall=1 for 4 cycles in OUT with instr=0x00500093: the outputs SHALL hold constant, then the FSM SHALL move to REQ one edge after stall falls.
REQ-037 pc_target=0x00010452 taken: pc SHALL become 0x00010450 and misalign_err SHALL pulse for exactly 1 cycle.
REQ-038 RESET_VECTOR=0xFFFFFFFC: the first fetch SHALL be at 0xFFFFFFFC and the second at 0x00000000.
REQ-039 rst asserted in WAIT, with the response arriving on the next cycle: instr_valid SHALL stay 0 and the next request SHALL be at RESET_VECTOR.
